stack_based_alu: RTL and testbench

- Clocked LIFO operand stack with an integrated signed adder and multiplier, controlled by a 3-bit opcode.
- A datapath helper: a master pushes operands and issues ADD/MUL/POP, then reads `output_data` and the signed `overflow` flag.
- One operation executes per clock in which a non-NOP opcode is present.

---
 rtl/stack_alu_pkg.sv | 13 +
 rtl/stack_based_alu_if.sv | 24 ++
 rtl/stack_alu_lifo.sv | 54 +++++
 rtl/stack_based_alu.sv | 135 +++++++++++++
 tb/tb_stack_based_alu.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/stack_alu_pkg.sv
// Shared constants for the stack-based ALU: opcode encodings and default sizing.
package stack_alu_pkg;

    localparam int DEF_N     = 32;
    localparam int DEF_DEPTH = 8;

    localparam logic [2:0] OP_PUSH = 3'b110;
    localparam logic [2:0] OP_POP  = 3'b111;
    localparam logic [2:0] OP_ADD  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_SUB  = 3'b011;

endpackage

// File: rtl/stack_based_alu_if.sv
// Operand/result bundle between a master issuing stack ops and the stack ALU.
interface stack_based_alu_if
    import stack_alu_pkg::*;
#(
    parameter int N = DEF_N
);
    logic [N-1:0] input_data;
    logic [2:0]   opcode;
    logic [N-1:0] output_data;
    logic         overflow;
    logic         stack_empty;
    logic         stack_full;
    logic         error;

    modport master (
        output input_data, opcode,
        input  output_data, overflow, stack_empty, stack_full, error
    );

    modport slave (
        input  input_data, opcode,
        output output_data, overflow, stack_empty, stack_full, error
    );
endinterface

// File: rtl/stack_alu_lifo.sv
// Register-array LIFO with one combined port: pop 0..2 entries and optionally push one,
// all in the same cycle. Legality (underflow/overflow) is the caller's responsibility.
module stack_alu_lifo #(
    parameter int N     = 32,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 pop_n,
    input  logic                       push,
    input  logic [N-1:0]               push_data,
    output logic [N-1:0]               top,
    output logic [N-1:0]               second,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int AW = $clog2(DEPTH);

    logic [N-1:0]  mem [DEPTH];
    logic [CW-1:0] count_q;
    logic [CW-1:0] base;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] second_idx;

    // Slot where a pushed value lands once the requested pops are applied.
    assign base       = count_q - CW'(pop_n);
    assign top_idx    = AW'(count_q - CW'(1));
    assign second_idx = AW'(count_q - CW'(2));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= base + CW'(push);
        end
    end

    // NOTE: the storage array has no reset; entries above count are never read, so their contents are irrelevant.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[base[AW-1:0]] <= push_data;
        end
    end

    assign top    = mem[top_idx];
    assign second = mem[second_idx];
    assign count  = count_q;
    assign full   = (count_q == CW'(DEPTH));
    assign empty  = (count_q == '0);

endmodule

// File: rtl/stack_based_alu.sv
// Stack-based ALU: PUSH/POP/ADD/MUL on a LIFO operand stack with signed overflow detection.
// Define STACK_ALU_SUB_EN to turn opcode 3'b011 into SUB (next minus top); otherwise it is a NOP.
module stack_based_alu
    import stack_alu_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    stack_based_alu_if.slave   bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [N-1:0]   top;
    logic [N-1:0]   second;
    logic [CW-1:0]  count;
    logic           full;
    logic           empty;
    logic [1:0]     pop_n;
    logic           push;
    logic [N-1:0]   push_data;

    logic           is_arith;
    logic [N-1:0]   alu_res;
    logic           alu_ovf;
    logic [2*N-1:0] top_ext;
    logic [2*N-1:0] second_ext;
    logic [2*N-1:0] prod;

    logic [N-1:0]   out_q, out_d;
    logic           ovf_q, ovf_d;
    logic           err_q, err_d;

    stack_alu_lifo #(.N(N), .DEPTH(DEPTH)) u_lifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .pop_n     (pop_n),
        .push      (push),
        .push_data (push_data),
        .top       (top),
        .second    (second),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Low 2N bits of a product of sign-extended operands equal the full signed product.
    assign top_ext    = {{N{top[N-1]}}, top};
    assign second_ext = {{N{second[N-1]}}, second};
    assign prod       = top_ext * second_ext;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        pop_n     = 2'd0;
        push      = 1'b0;
        push_data = bus.input_data;
        out_d     = out_q;
        ovf_d     = ovf_q;
        err_d     = 1'b0;
        is_arith  = 1'b0;
        alu_res   = top + second;
        alu_ovf   = 1'b0;

        case (bus.opcode)
            OP_PUSH: begin
                if (full) begin
                    err_d = 1'b1;
                end else begin
                    push  = 1'b1;
                    ovf_d = 1'b0;
                end
            end
            OP_POP: begin
                if (empty) begin
                    err_d = 1'b1;
                end else begin
                    pop_n = 2'd1;
                    out_d = top;
                    ovf_d = 1'b0;
                end
            end
            OP_ADD: begin
                is_arith = 1'b1;
                alu_res  = top + second;
                alu_ovf  = (top[N-1] == second[N-1]) && (alu_res[N-1] != top[N-1]);
            end
            OP_MUL: begin
                is_arith = 1'b1;
                alu_res  = prod[N-1:0];
                alu_ovf  = (prod[2*N-1:N-1] != {(N+1){prod[2*N-1]}});
            end
`ifdef STACK_ALU_SUB_EN
            OP_SUB: begin
                is_arith = 1'b1;
                alu_res  = second - top;
                alu_ovf  = (top[N-1] != second[N-1]) && (alu_res[N-1] != second[N-1]);
            end
`endif
            default: ;
        endcase

        // Binary ops pop both operands and push the result in a single cycle.
        if (is_arith) begin
            if (count < CW'(2)) begin
                err_d = 1'b1;
            end else begin
                pop_n     = 2'd2;
                push      = 1'b1;
                push_data = alu_res;
                out_d     = alu_res;
                ovf_d     = alu_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            out_q <= out_d;
            ovf_q <= ovf_d;
            err_q <= err_d;
        end
    end

    assign bus.output_data = out_q;
    assign bus.overflow    = ovf_q;
    assign bus.error       = err_q;
    assign bus.stack_empty = empty;
    assign bus.stack_full  = full;

endmodule

// File: tb/tb_stack_based_alu.sv
// Self-checking bench for stack_based_alu: directed vector table, hand-written corner
// sequences, then random ops scored against a queue-based reference model.
module tb_stack_based_alu;
    import stack_alu_pkg::*;

    localparam int N     = 32;
    localparam int DEPTH = 8;

    typedef struct {
        logic [2:0]   op;
        logic [N-1:0] data;
        logic [N-1:0] exp_out;
        logic         exp_ovf;
        logic         exp_err;
        logic         exp_empty;
        logic         exp_full;
    } vec_t;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    vec_t         vecs[$];
    logic [N-1:0] model_q[$];
    logic [N-1:0] m_out;
    logic         m_ovf;
    logic         m_err;

    stack_based_alu_if #(.N(N)) bus ();

    stack_based_alu #(.N(N), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [N-1:0] e_out, input logic e_ovf,
                             input logic e_err, input logic e_empty, input logic e_full);
        check({tag, ".output_data"}, 64'(bus.output_data), 64'(e_out));
        check({tag, ".overflow"},    64'(bus.overflow),    64'(e_ovf));
        check({tag, ".error"},       64'(bus.error),       64'(e_err));
        check({tag, ".stack_empty"}, 64'(bus.stack_empty), 64'(e_empty));
        check({tag, ".stack_full"},  64'(bus.stack_full),  64'(e_full));
    endtask

    // Present one opcode for exactly one rising edge, then sample just after it.
    task automatic step(input logic [2:0] op, input logic [N-1:0] data);
        @(negedge clk);
        bus.opcode     = op;
        bus.input_data = data;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.opcode = 3'b000;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_q.delete();
        m_out = '0;
        m_ovf = 1'b0;
        m_err = 1'b0;
    endtask

    function automatic void add_vec(input logic [2:0] op, input logic [N-1:0] d, input logic [N-1:0] o,
                                    input logic v, input logic e, input logic em, input logic fu);
        vec_t r;
        r.op = op; r.data = d; r.exp_out = o; r.exp_ovf = v;
        r.exp_err = e; r.exp_empty = em; r.exp_full = fu;
        vecs.push_back(r);
    endfunction

    // Reference model: a queue whose back is the top, arithmetic in 64-bit signed integers.
    function automatic void model_step(input logic [2:0] op, input logic [N-1:0] d);
        logic [N-1:0] a, b;
        longint       r;
        bit           binop;
        binop = 1'b0;
        r     = 0;
        m_err = 1'b0;
        case (op)
            OP_PUSH: if (model_q.size() == DEPTH) m_err = 1'b1;
                     else begin model_q.push_back(d); m_ovf = 1'b0; end
            OP_POP:  if (model_q.size() == 0) m_err = 1'b1;
                     else begin m_out = model_q.pop_back(); m_ovf = 1'b0; end
            OP_ADD, OP_MUL: binop = 1'b1;
`ifdef STACK_ALU_SUB_EN
            OP_SUB: binop = 1'b1;
`endif
            default: ;
        endcase
        if (binop) begin
            if (model_q.size() < 2) begin
                m_err = 1'b1;
            end else begin
                a = model_q.pop_back();
                b = model_q.pop_back();
                if (op == OP_ADD)      r = longint'($signed(a)) + longint'($signed(b));
                else if (op == OP_MUL) r = longint'($signed(a)) * longint'($signed(b));
                else                   r = longint'($signed(b)) - longint'($signed(a));
                m_out = r[N-1:0];
                m_ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
                model_q.push_back(m_out);
            end
        end
    endfunction

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.opcode     = 3'b000;
        bus.input_data = '0;

        //       op       data          out           ovf   err   empty full
        add_vec(OP_PUSH, 32'd10,       32'd0,        1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(OP_PUSH, 32'd20,       32'd0,        1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(OP_ADD,  32'd0,        32'd30,       1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(OP_PUSH, 32'd3,        32'd30,       1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(OP_PUSH, 32'd4,        32'd30,       1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(OP_MUL,  32'd0,        32'd12,       1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(OP_POP,  32'd0,        32'd12,       1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(OP_POP,  32'd0,        32'd30,       1'b0, 1'b0, 1'b1, 1'b0);
        add_vec(OP_POP,  32'd0,        32'd30,       1'b0, 1'b1, 1'b1, 1'b0);
        add_vec(3'b000,  32'd0,        32'd30,       1'b0, 1'b0, 1'b1, 1'b0);
        add_vec(OP_PUSH, 32'h7FFFFFFF, 32'd30,       1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(OP_PUSH, 32'd1,        32'd30,       1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(OP_ADD,  32'd0,        32'h80000000, 1'b1, 1'b0, 1'b0, 1'b0);
        add_vec(OP_ADD,  32'd0,        32'h80000000, 1'b1, 1'b1, 1'b0, 1'b0);
        add_vec(OP_POP,  32'd0,        32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0);
        add_vec(OP_PUSH, 32'h80000000, 32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(OP_PUSH, 32'd2,        32'h80000000, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(OP_MUL,  32'd0,        32'd0,        1'b1, 1'b0, 1'b0, 1'b0);
        add_vec(OP_PUSH, 32'hFFFFFFFD, 32'd0,        1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(OP_PUSH, 32'd5,        32'd0,        1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(OP_MUL,  32'd0,        32'hFFFFFFF1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(OP_POP,  32'd0,        32'hFFFFFFF1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(OP_POP,  32'd0,        32'd0,        1'b0, 1'b0, 1'b1, 1'b0);
        add_vec(OP_PUSH, 32'd5,        32'd0,        1'b0, 1'b0, 1'b0, 1'b0);
        add_vec(OP_MUL,  32'd0,        32'd0,        1'b0, 1'b1, 1'b0, 1'b0);
        add_vec(3'b010,  32'd9,        32'd0,        1'b0, 1'b0, 1'b0, 1'b0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all("reset", '0, 1'b0, 1'b0, 1'b1, 1'b0);
        do_reset();

        foreach (vecs[i]) begin
            step(vecs[i].op, vecs[i].data);
            check_all($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_ovf,
                      vecs[i].exp_err, vecs[i].exp_empty, vecs[i].exp_full);
        end

        // Fill from one entry to DEPTH, then one push too many.
        for (int i = 1; i < DEPTH; i++) step(OP_PUSH, N'(100 + i));
        check_all("fill", '0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(OP_PUSH, 32'd999);
        check_all("push_full", '0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(OP_POP, '0);
        check_all("pop_after_full", N'(100 + DEPTH - 1), 1'b0, 1'b0, 1'b0, 1'b0);
        step(OP_POP, '0);
        check_all("pop_before_rst", N'(100 + DEPTH - 2), 1'b0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in the middle of a PUSH cycle.
        @(negedge clk);
        bus.opcode     = OP_PUSH;
        bus.input_data = 32'd77;
        #2;
        rst_n = 1'b0;
        #1;
        check_all("async_rst", '0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check_all("rst_held", '0, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        bus.opcode = 3'b000;
        rst_n = 1'b1;
        step(3'b000, '0);
        check_all("rst_release", '0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef STACK_ALU_SUB_EN
        step(OP_PUSH, 32'd10);
        step(OP_PUSH, 32'd3);
        step(OP_SUB, '0);
        check_all("sub", 32'd7, 1'b0, 1'b0, 1'b0, 1'b0);
        step(OP_PUSH, 32'h80000000);
        step(OP_PUSH, 32'd1);
        step(OP_SUB, '0);
        check_all("sub_ovf", 32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
`endif

        // Random operations against the reference model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            logic [2:0]   op;
            logic [N-1:0] d;
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) op = OP_PUSH;
            d = $urandom_range(0, 3) == 0 ? N'($urandom_range(0, 20)) - N'(10) : N'($urandom);
            model_step(op, d);
            step(op, d);
            check_all($sformatf("rnd%0d", i), m_out, m_ovf, m_err,
                      model_q.size() == 0, model_q.size() == DEPTH);
        end

        @(negedge clk);
        bus.opcode = 3'b000;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
